cache_fill_sequencer: RTL and testbench

- Parametrised successor to the cache word-enable decoder.
- Sequences a full cache-block refill from a pipelined, in-order memory:
  - issues one word request per cycle;
  - counts the returning words;
  - drives a one-hot data-array word enable for each returning word;
  - pulses fill_done, which the cache controller uses as the tag/valid write.
- Sits between the cache miss FSM and the memory port.
- Optional critical-word-first ordering.

---
 rtl/cache_pkg.sv | 19 +
 rtl/onehot_decoder.sv | 16 +
 rtl/cache_fill_sequencer.sv | 117 +++++++++++
 tb/tb_cache_fill_sequencer.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared cache definitions: fill FSM states, default geometry, log2 helper.
package cache_pkg;

   localparam int CACHE_WORDS      = 8;
   localparam int CACHE_WORD_BYTES = 2;
   localparam int CACHE_ADDR_W     = 16;

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} fill_state_t;

   // ceil(log2(value)); returns 0 for value <= 1
   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++)
         if ((1 << i) < value) r = i + 1;
      return r;
   endfunction

endpackage

// File: rtl/onehot_decoder.sv
// Index-to-one-hot decoder with enable; all zeros when en is low.
module onehot_decoder import cache_pkg::*; #(
   parameter int N = CACHE_WORDS
) (
   input  logic [clog2(N)-1:0] idx,
   input  logic                en,
   output logic [N-1:0]        onehot
);

   // set exactly the indexed bit when enabled
   always_comb begin
      onehot = '0;
      if (en) onehot[idx] = 1'b1;
   end

endmodule

// File: rtl/cache_fill_sequencer.sv
// Cache block refill sequencer: issues WORDS in-order word reads, tracks the
// returning words, drives a one-hot data-array write enable per word and
// pulses fill_done for the tag/valid write. Optional critical-word-first.
module cache_fill_sequencer import cache_pkg::*; #(
   parameter int WORDS      = CACHE_WORDS,
   parameter int WORD_BYTES = CACHE_WORD_BYTES,
   parameter int ADDR_W     = CACHE_ADDR_W,
   parameter int CWF        = 0
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      miss_valid,
   input  logic [ADDR_W-1:0]         miss_addr,
   output logic                      miss_ready,
   output logic                      mem_req_valid,
   output logic [ADDR_W-1:0]         mem_req_addr,
   input  logic                      mem_req_stall,
   input  logic                      mem_rsp_valid,
   output logic [WORDS-1:0]          word_enable,
   output logic [clog2(WORDS)-1:0]   word_idx,
   output logic                      fill_busy,
   output logic                      fill_done
);

   localparam int IDX_W = clog2(WORDS);
   localparam int WB_W  = clog2(WORD_BYTES);
   localparam int OFF_W = IDX_W + WB_W;
   localparam int CNT_W = IDX_W + 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WORDS - 1);

   fill_state_t       state, state_nxt;
   logic [ADDR_W-1:0] base;
   logic [IDX_W-1:0]  issue_idx, rsp_idx, start_idx;
   logic [CNT_W-1:0]  issue_cnt, rsp_cnt, issue_cnt_eff;
   logic              accept, req_fire, rsp_fire;

   assign start_idx = (CWF != 0) ? miss_addr[OFF_W-1:WB_W] : '0;
   assign accept    = (state == IDLE) && miss_valid;
   assign req_fire  = (state == ISSUE) && !mem_req_stall;
   // a request accepted this cycle may be answered in the same cycle
   assign issue_cnt_eff = issue_cnt + CNT_W'(req_fire);
   assign rsp_fire  = ((state == ISSUE) || (state == DRAIN)) && mem_rsp_valid &&
                      (rsp_cnt < issue_cnt_eff);

   // request address depends only on registered state, never on miss_*
   assign mem_req_addr = mem_req_valid ? (base | (ADDR_W'(issue_idx) << WB_W)) : '0;
   assign word_idx     = rsp_idx;

   onehot_decoder #(.N(WORDS)) u_dec (
      .idx    (rsp_idx),
      .en     (rsp_fire),
      .onehot (word_enable)
   );

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // FSM next state and status outputs
   always_comb begin
      state_nxt     = state;
      miss_ready    = 1'b0;
      mem_req_valid = 1'b0;
      fill_busy     = 1'b0;
      fill_done     = 1'b0;
      case (state)
         IDLE: begin
            miss_ready = 1'b1;
            if (miss_valid) state_nxt = ISSUE;
         end
         ISSUE: begin
            mem_req_valid = 1'b1;
            fill_busy     = 1'b1;
            if (rsp_fire && rsp_cnt == LAST)        state_nxt = DONE;
            else if (req_fire && issue_cnt == LAST) state_nxt = DRAIN;
         end
         DRAIN: begin
            fill_busy = 1'b1;
            if (rsp_fire && rsp_cnt == LAST) state_nxt = DONE;
         end
         DONE: begin
            fill_done = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // base latch, issue/response indices and counters
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         base      <= '0;
         issue_idx <= '0;
         rsp_idx   <= '0;
         issue_cnt <= '0;
         rsp_cnt   <= '0;
      end else if (accept) begin
         base      <= {miss_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
         issue_idx <= start_idx;
         rsp_idx   <= start_idx;
         issue_cnt <= '0;
         rsp_cnt   <= '0;
      end else begin
         if (req_fire) begin
            issue_idx <= issue_idx + 1'b1;
            issue_cnt <= issue_cnt + 1'b1;
         end
         if (rsp_fire) begin
            rsp_idx <= rsp_idx + 1'b1;
            rsp_cnt <= rsp_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_cache_fill_sequencer.sv
// Directed bench: two sequencers (CWF=0 and CWF=1) share stimulus and a
// 4-cycle in-order memory model.
module tb_cache_fill_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst = 1'b0;
   logic        miss_valid = 1'b0;
   logic [15:0] miss_addr = 16'h0;
   logic        mem_req_stall = 1'b0;
   logic        rsp_force = 1'b0;
   logic [3:0]  pipe = 4'h0;
   logic        mem_rsp_valid;

   logic        ready0, ready1, rv0, rv1, busy0, busy1, done0, done1;
   logic [15:0] ra0, ra1;
   logic [7:0]  we0, we1;
   logic [2:0]  idx0, idx1;

   assign mem_rsp_valid = pipe[3] | rsp_force;

   // memory: a request accepted at an edge returns 4 edges later; not reset
   always @(posedge clk) pipe <= {pipe[2:0], rv0 & ~mem_req_stall};

   cache_fill_sequencer #(.WORDS(8), .WORD_BYTES(2), .ADDR_W(16), .CWF(0)) dut0 (
      .clk(clk), .rst(rst), .miss_valid(miss_valid), .miss_addr(miss_addr),
      .miss_ready(ready0), .mem_req_valid(rv0), .mem_req_addr(ra0),
      .mem_req_stall(mem_req_stall), .mem_rsp_valid(mem_rsp_valid),
      .word_enable(we0), .word_idx(idx0), .fill_busy(busy0), .fill_done(done0));

   cache_fill_sequencer #(.WORDS(8), .WORD_BYTES(2), .ADDR_W(16), .CWF(1)) dut1 (
      .clk(clk), .rst(rst), .miss_valid(miss_valid), .miss_addr(miss_addr),
      .miss_ready(ready1), .mem_req_valid(rv1), .mem_req_addr(ra1),
      .mem_req_stall(mem_req_stall), .mem_rsp_valid(mem_rsp_valid),
      .word_enable(we1), .word_idx(idx1), .fill_busy(busy1), .fill_done(done1));

   logic [15:0] exp_addr0 [8] = '{16'h1230, 16'h1232, 16'h1234, 16'h1236,
                                  16'h1238, 16'h123A, 16'h123C, 16'h123E};
   logic [15:0] exp_addr1 [8] = '{16'h1236, 16'h1238, 16'h123A, 16'h123C,
                                  16'h123E, 16'h1230, 16'h1232, 16'h1234};
   logic [7:0]  exp_we0 [8]   = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
   logic [7:0]  exp_we1 [8]   = '{8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01, 8'h02, 8'h04};
   logic [2:0]  exp_idx1 [8]  = '{3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1, 3'd2};

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // one full fill of miss 0x1236 on both DUTs; stall_n stall cycles at 0x1232
   task automatic run_fill(input int stall_n);
      int r0, r1, w0, w1, done_cnt, done_cyc, last_we0, first_req, last_req, hold, st;
      r0 = 0; r1 = 0; w0 = 0; w1 = 0; done_cnt = 0; done_cyc = -10; last_we0 = -10;
      first_req = 0; last_req = 0; hold = 0; st = 0;
      miss_valid = 1'b1; miss_addr = 16'h1236;
      @(negedge clk);
      miss_valid = 1'b0;
      chk("accept_ready", ready0, 0);
      chk("accept_busy", busy0, 1);
      for (int cyc = 0; cyc < 40; cyc++) begin
         if (done_cnt != 0 && cyc == done_cyc + 1) break;
         if (rv0) begin
            if (r0 < 8) chk("req_addr0", ra0, exp_addr0[r0]);
            else        chk("req_extra0", r0, 7);
            if (ra0 == 16'h1232) hold++;
            if (ra0 == 16'h1232 && st < stall_n) begin mem_req_stall = 1'b1; st++; end
            else mem_req_stall = 1'b0;
            if (!mem_req_stall) begin
               if (r0 == 0) first_req = cyc;
               last_req = cyc;
               r0++;
            end
         end else mem_req_stall = 1'b0;
         if (rv1) begin
            if (r1 < 8) chk("req_addr1", ra1, exp_addr1[r1]);
            else        chk("req_extra1", r1, 7);
            if (!mem_req_stall) r1++;
         end
         if (we0 != 8'h0) begin
            if (w0 < 8) begin
               chk("word_en0", we0, exp_we0[w0]);
               chk("word_idx0", idx0, w0);
            end else chk("we_extra0", w0, 7);
            last_we0 = cyc;
            w0++;
         end
         if (we1 != 8'h0) begin
            if (w1 < 8) begin
               chk("word_en1", we1, exp_we1[w1]);
               chk("word_idx1", idx1, exp_idx1[w1]);
            end else chk("we_extra1", w1, 7);
            w1++;
         end
         if (done0) begin
            chk("done_sync1", done1, 1);
            done_cnt++;
            done_cyc = cyc;
         end
         @(negedge clk);
      end
      mem_req_stall = 1'b0;
      chk("done_count", done_cnt, 1);
      chk("req_count0", r0, 8);
      chk("req_count1", r1, 8);
      chk("we_count0", w0, 8);
      chk("we_count1", w1, 8);
      chk("done_after_last_we", done_cyc - last_we0, 1);
      chk("ready_after_done", ready0, 1);
      chk("done_one_cycle", done0, 0);
      if (stall_n == 0) chk("req_consecutive", last_req - first_req, 7);
      else              chk("stall_hold_cycles", hold, stall_n + 1);
   endtask

   initial begin
      int w0, pulses, seen;

      // reset state
      #1 rst = 1'b1;
      #1;
      chk("rst_ready", ready0, 1);
      chk("rst_req_valid", rv0, 0);
      chk("rst_req_addr", ra0, 0);
      chk("rst_we", we0, 0);
      chk("rst_idx", idx0, 0);
      chk("rst_busy", busy0, 0);
      chk("rst_done", done0, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // in-order and critical-word-first fills, no stall
      run_fill(0);
      @(negedge clk);
      // 3 stall cycles while requesting 0x1232
      run_fill(3);
      @(negedge clk);

      // asynchronous reset after 3 responses
      miss_valid = 1'b1; miss_addr = 16'h1236;
      @(negedge clk);
      miss_valid = 1'b0;
      w0 = 0;
      for (int cyc = 0; cyc < 30; cyc++) begin
         if (we0 != 8'h0) w0++;
         if (w0 == 3) break;
         @(negedge clk);
      end
      chk("pre_rst_responses", w0, 3);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("midrst_ready", ready0, 1);
      chk("midrst_req_valid", rv0, 0);
      chk("midrst_req_addr", ra0, 0);
      chk("midrst_we", we0 | we1, 0);
      chk("midrst_busy", busy0 | busy1, 0);
      @(negedge clk);
      rst = 1'b0;
      pulses = 0;
      for (int cyc = 0; cyc < 12; cyc++) begin
         if (mem_rsp_valid) pulses++;
         chk("stale_rsp_we", we0 | we1, 0);
         chk("stale_rsp_done", done0 | done1, 0);
         chk("stale_rsp_ready", ready0, 1);
         @(negedge clk);
      end
      chk("stale_rsp_seen", pulses > 0, 1);

      // spurious response in IDLE, second miss during ISSUE
      rsp_force = 1'b1;
      #1;
      chk("idle_rsp_we0", we0, 0);
      chk("idle_rsp_we1", we1, 0);
      @(negedge clk);
      rsp_force = 1'b0;
      chk("idle_rsp_ready", ready0, 1);
      miss_valid = 1'b1; miss_addr = 16'h1236;
      @(negedge clk);
      miss_addr = 16'h4440;
      chk("issue_ready", ready0, 0);
      chk("issue_addr_a", ra0, 16'h1230);
      @(negedge clk);
      miss_valid = 1'b0;
      chk("base_kept0", ra0, 16'h1232);
      chk("base_kept1", ra1, 16'h1238);
      seen = 0;
      for (int cyc = 0; cyc < 40; cyc++) begin
         if (done0) begin
            rsp_force = 1'b1;
            #1;
            chk("done_rsp_we", we0, 0);
            rsp_force = 1'b0;
            seen = 1;
            break;
         end
         @(negedge clk);
      end
      chk("second_fill_done", seen, 1);
      @(negedge clk);
      @(negedge clk);

      // miss_valid held high: back-to-back fills
      miss_valid = 1'b1; miss_addr = 16'h1236;
      for (int k = 0; k < 2; k++) begin
         seen = 0;
         for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (done0) begin seen = 1; break; end
         end
         chk("b2b_done", seen, 1);
         @(negedge clk);
         chk("b2b_idle_ready", ready0, 1);
         chk("b2b_idle_busy", busy0, 0);
         @(negedge clk);
         chk("b2b_restart_busy", busy0, 1);
         chk("b2b_restart_ready", ready0, 0);
         chk("b2b_restart_addr", ra0, 16'h1230);
      end
      miss_valid = 1'b0;
      seen = 0;
      for (int cyc = 0; cyc < 40; cyc++) begin
         @(negedge clk);
         if (done0) begin seen = 1; break; end
      end
      chk("b2b_last_done", seen, 1);
      @(negedge clk);
      chk("final_ready", ready0, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
